// File: rtl/conv_2d_pkg.sv
// conv_2d_pkg: shared FSM state type and width helpers for the streaming 2-D convolver
package conv_2d_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_K,
        S_STREAM,
        S_DRAIN
    } state_e;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int acc_w_f(input int dw, input int k);
        return 2 * dw + clog2_f(k * k);
    endfunction

    function automatic int cnt_w_f(input int n);
        return (n <= 2) ? 1 : clog2_f(n);
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: one image row of delay, advancing only on accepted pixels
module conv_line_buf #(
    parameter int IMG_W = 5,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    logic [DW-1:0] mem_q [IMG_W];

    // shift one pixel in per enable; the tail is the pixel one row above
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IMG_W; i++) mem_q[i] <= '0;
        end else if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < IMG_W; i++) mem_q[i] <= mem_q[i-1];
        end
    end

    assign dout_o = mem_q[IMG_W-1];

endmodule

// File: rtl/conv_2d_stream.sv
// conv_2d_stream: streaming KxK convolution with kernel load, line buffers and 3-stage MAC pipeline
// Define CONV2D_SAT_EN to clamp the result to 2**DW-1; otherwise the full ACC_W sum is output.
module conv_2d_stream
    import conv_2d_pkg::*;
#(
    parameter  int IMG_W = 5,
    parameter  int IMG_H = 5,
    parameter  int K     = 3,
    parameter  int DW    = 8,
    localparam int ACC_W = acc_w_f(DW, K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             k_valid,
    input  logic [DW-1:0]    k_data,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out,
    input  logic             out_ready,
    output logic             done
);

    localparam int KK = K * K;
    localparam int CW = cnt_w_f(IMG_W);
    localparam int RW = cnt_w_f(IMG_H);
    localparam int KW = cnt_w_f(KK);
    localparam int PW = 2 * DW;
`ifdef CONV2D_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW){1'b0}}, {DW{1'b1}}};
`endif

    state_e           state_q, state_d;
    logic [KW-1:0]    k_idx_q;
    logic [DW-1:0]    coef_q [KK];
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [DW-1:0]    win_q [KK];
    logic [DW-1:0]    win_d [KK];
    logic [DW-1:0]    chain [K];
    logic [PW-1:0]    prod_q [KK];
    logic [PW-1:0]    prod_d [KK];
    logic [ACC_W-1:0] sum_q, sum_d, out_q, out_d;
    logic             pv_q, sv_q, ov_q, done_q, done_d;
    logic             adv, accept, last_px, win_ok, last_out;

    // a full output register that is not being taken freezes the whole pipeline
    assign adv       = !(ov_q && !out_ready);
    assign in_ready  = (state_q == S_STREAM) && adv;
    assign accept    = in_valid && in_ready;
    assign last_px   = (col_q == CW'(IMG_W-1)) && (row_q == RW'(IMG_H-1));
    assign win_ok    = (col_q >= CW'(K-1)) && (row_q >= RW'(K-1));
    assign last_out  = ov_q && out_ready && !pv_q && !sv_q;
    assign out_valid = ov_q;
    assign out       = out_q;
    assign done      = done_q;

    // chain[0] is the incoming pixel, chain[m] the same column m rows above
    assign chain[0] = in_data;
    genvar g;
    for (g = 0; g < K - 1; g++) begin : g_lb
        conv_line_buf #(.IMG_W(IMG_W), .DW(DW)) u_lb (
            .clk    (clk),
            .rst    (rst),
            .en_i   (accept),
            .din_i  (chain[g]),
            .dout_o (chain[g+1])
        );
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // next state and frame-end pulse
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD_K;
            S_LOAD_K: if (k_valid && k_idx_q == KW'(KK-1)) state_d = S_STREAM;
            S_STREAM: if (accept && last_px) state_d = S_DRAIN;
            S_DRAIN:  if (last_out) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // coefficients are captured row-major and kept across frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_idx_q <= '0;
            for (int n = 0; n < KK; n++) coef_q[n] <= '0;
        end else if (state_q == S_LOAD_K && k_valid) begin
            coef_q[k_idx_q] <= k_data;
            k_idx_q         <= (k_idx_q == KW'(KK-1)) ? '0 : k_idx_q + 1'b1;
        end
    end

    // raster position of the next pixel; wraps to zero at frame end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            col_q <= (col_q == CW'(IMG_W-1)) ? '0 : col_q + 1'b1;
            if (col_q == CW'(IMG_W-1)) row_q <= (row_q == RW'(IMG_H-1)) ? '0 : row_q + 1'b1;
        end
    end

    // shift the window left and insert the new column; products come from the updated window
    always_comb begin
        for (int n = 0; n < KK; n++) win_d[n] = win_q[n];
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) win_d[i*K+j] = win_q[i*K+j+1];
                win_d[i*K+K-1] = chain[K-1-i];
            end
        end
        for (int n = 0; n < KK; n++) prod_d[n] = {{DW{1'b0}}, win_d[n]} * {{DW{1'b0}}, coef_q[n]};
    end

    // window register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < KK; n++) win_q[n] <= '0;
        end else begin
            for (int n = 0; n < KK; n++) win_q[n] <= win_d[n];
        end
    end

    // adder tree and optional clamp
    always_comb begin
        sum_d = '0;
        for (int n = 0; n < KK; n++) sum_d = sum_d + ACC_W'(prod_q[n]);
`ifdef CONV2D_SAT_EN
        out_d = (sum_q > SAT_MAX) ? SAT_MAX : sum_q;
`else
        out_d = sum_q;
`endif
    end

    // product, sum and output stages advance together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv_q  <= 1'b0;
            sv_q  <= 1'b0;
            ov_q  <= 1'b0;
            sum_q <= '0;
            out_q <= '0;
            for (int n = 0; n < KK; n++) prod_q[n] <= '0;
        end else if (adv) begin
            pv_q  <= accept && win_ok;
            sv_q  <= pv_q;
            ov_q  <= sv_q;
            sum_q <= sum_d;
            for (int n = 0; n < KK; n++) prod_q[n] <= prod_d[n];
            if (sv_q) out_q <= out_d;
        end
    end

    // one-cycle done pulse after the final result leaves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) done_q <= 1'b0;
        else      done_q <= done_d;
    end

endmodule

// File: tb/tb_conv_2d_stream.sv
// tb_conv_2d_stream: directed self-checking bench for conv_2d_stream on a 5x5 image, 3x3 kernel
module tb_conv_2d_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        k_valid = 1'b0;
    logic [7:0]  k_data = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [19:0] out;
    logic        out_ready = 1'b1;
    logic        done;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_done = 0;
    logic [19:0] got [$];
    logic [7:0]  kern [9];
    int          exp_a [9] = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
    int          exp_b [9] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
    int          exp_d [9];

    always #5 clk = ~clk;

    conv_2d_stream #(.IMG_W(5), .IMG_H(5), .K(3), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_valid   (k_valid),
        .k_data    (k_data),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out       (out),
        .out_ready (out_ready),
        .done      (done)
    );

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) got.push_back(out);
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic set_kern(input int mode);
        for (int i = 0; i < 9; i++)
            kern[i] = (mode == 0) ? 8'd1 : (mode == 1) ? ((i == 4) ? 8'd1 : 8'd0) : 8'd255;
    endtask

    task automatic load_kernel();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            k_valid = 1'b1;
            k_data  = kern[i];
            @(negedge clk);
            check("load_rdy", in_ready, 0);
            @(posedge clk); #1;
        end
        k_valid = 1'b0;
    endtask

    task automatic stream(input int n, input int fill, input int stall_at, input int held);
        int p;
        bit acc;
        p = 0;
        for (int g = 0; g < 400 && p < n; g++) begin
            if (p == stall_at) begin
                stall_at  = -1;
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("stall_rdy", in_ready, 0);
                    check("stall_vld", out_valid, 1);
                    check("stall_out", out, held);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            in_valid = 1'b1;
            in_data  = (fill == 0) ? 8'(p + 1) : 8'(fill);
            @(negedge clk);
            if (p == 14) check("lat_pre", out_valid, 0);
            if (p == 15) check("lat_on", out_valid, 1);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) p++;
        end
        in_valid = 1'b0;
        check("stream_n", p, n);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = done;
        end
        check("done", seen, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_seq(input string tag, input int e [9]);
        check({tag, "_cnt"}, got.size(), 9);
        for (int i = 0; i < 9 && i < got.size(); i++) check(tag, got[i], e[i]);
        got.delete();
    endtask

    task automatic run_frame(input string tag, input int mode, input int fill, input int stall_at,
                             input int held, input int e [9]);
        set_kern(mode);
        load_kernel();
        stream(25, fill, stall_at, held);
        wait_done();
        check_seq(tag, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int done_before;
        for (int i = 0; i < 9; i++) begin
`ifdef CONV2D_SAT_EN
            exp_d[i] = 255;
`else
            exp_d[i] = 585225;
`endif
        end
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", in_ready, 0);
        check("rst_vld", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_frame("ones", 0, 0, -1, 0, exp_a);
        run_frame("centre", 1, 0, -1, 0, exp_b);
        run_frame("stall", 0, 0, 15, 63, exp_a);
        run_frame("max", 2, 255, -1, 0, exp_d);

        set_kern(0);
        load_kernel();
        stream(12, 0, -1, 0);
        done_before = n_done;
        rst = 1'b0;
        #2;
        check("mid_rst_rdy", in_ready, 0);
        check("mid_rst_vld", out_valid, 0);
        check("mid_rst_out", out, 0);
        check("mid_rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_none", got.size(), 0);
        check("mid_rst_ndone", n_done, done_before);
        run_frame("after_rst", 0, 0, -1, 0, exp_a);

        in_valid = 1'b1;
        in_data  = 8'd200;
        @(negedge clk);
        check("idle_rdy", in_ready, 0);
        @(posedge clk); #1;
        run_frame("reload", 1, 0, -1, 0, exp_b);

        check("n_done", n_done, 6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_2d_stream.md
CONV_2D_STREAM -- requirements
Module: conv_2d_stream

Interface
REQ-001 SHALL have parameter IMG_W, default 5: image width in pixels (>= K).
REQ-002 SHALL have parameter IMG_H, default 5: image height in rows (>= K).
REQ-003 SHALL have parameter K, default 3: square kernel size (2..7).
REQ-004 SHALL have parameter DW, default 8: pixel and coefficient width, unsigned.
REQ-005 SHALL have localparam ACC_W = 2*DW + clog2(K*K): output width.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1: begins a frame when in IDLE.
REQ-009 SHALL have port k_valid, input, 1: coefficient on k_data is valid.
REQ-010 SHALL have port k_data, input, DW: kernel coefficient, row-major.
REQ-011 SHALL have port in_valid, input, 1: pixel on in_data is valid.
REQ-012 SHALL have port in_data, input, DW: image pixel, raster order.
REQ-013 SHALL have port in_ready, output, 1: pixel accepted when in_valid && in_ready.
REQ-014 SHALL have port out_valid, output, 1: out holds a result.
REQ-015 SHALL have port out, output, ACC_W: convolution result.
REQ-016 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-017 SHALL have port done, output, 1: one-cycle pulse at frame end.

Function
REQ-018 SHALL implement FSM IDLE -> LOAD_K -> STREAM -> DRAIN -> IDLE.
REQ-019 IDLE: start=1 SHALL move to LOAD_K; start ignored in all other states.
REQ-020 LOAD_K: each k_valid cycle SHALL store k_data at index 0..K*K-1; after index K*K-1, move to STREAM; k_valid ignored outside LOAD_K.
REQ-021 STREAM: in_ready SHALL be 1 unless output register full and out_ready=0.
REQ-022 Each accepted pixel SHALL be written to K-1 row line buffers plus a KxK window; column/row counters SHALL wrap at IMG_W-1 and IMG_H-1.
REQ-023 A window SHALL be valid when accepted pixel has col >= K-1 and row >= K-1; only valid windows produce output ((IMG_W-K+1)*(IMG_H-K+1) results per frame, raster order).
REQ-024 Result SHALL be sum over i,j of window[i][j]*coef[i][j], unsigned, full ACC_W precision, no overflow possible.
REQ-025 Pipeline: product stage, adder-tree stage, output register; out_valid SHALL assert exactly 2 cycles after the accepting edge of the completing pixel when unstalled.
REQ-026 Stall SHALL freeze all pipeline stages; no result lost or duplicated.
REQ-027 After the last pixel (row IMG_H-1, col IMG_W-1) is accepted, SHALL enter DRAIN with in_ready=0.
REQ-028 DRAIN: when final result is consumed, done SHALL pulse 1 cycle and FSM returns to IDLE; kernel coefficients retained.
REQ-029 in_valid outside STREAM SHALL be ignored (in_ready=0).

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, counters 0, coefficients 0, line buffers/window 0, in_ready=0, out_valid=0, out=0, done=0.
REQ-031 Reset mid-frame SHALL discard all in-flight results; no done pulse.

Configuration
REQ-032 With CONV2D_SAT_EN defined, out SHALL clamp to 2**DW-1 when sum exceeds it (upper bits zero); without it, out carries the full ACC_W sum.

Structure
REQ-033 Package conv_2d_pkg SHALL hold the FSM state enum and the ACC_W/counter-width functions.
REQ-034 Line buffers SHALL be a sub-module conv_line_buf (parameters IMG_W, DW; one row delay, enable-driven).

Verification
REQ-035 Defaults, kernel all 1s, pixels 1..25 -> outputs 63,72,81,108,117,126,153,162,171, then done pulse.
REQ-036 Kernel centre 1 else 0, pixels 1..25 -> outputs 7,8,9,12,13,14,17,18,19.
REQ-037 out_ready low 5 cycles mid-frame -> in_ready low, out held stable, full 9-result sequence unchanged.
REQ-038 All pixels and coefs 255 -> out=585225 without CONV2D_SAT_EN, 255 with it.
REQ-039 rst low after 12 pixels, then new frame -> IDLE, outputs 0, second frame matches REQ-035.
REQ-040 Second start without reloading kernel flow -> LOAD_K required; in_valid during LOAD_K ignored, outputs unaffected.
